// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop deserialiser onto a valid/ready stream.
// Define UART_RX_SYNC_EN to add a 2-flop synchroniser on uart_rxd.
`timescale 1ns/1ps
module uart_rx #(
    parameter int    DW = 8,
    parameter string PT = "NONE",
    parameter int    SW = 1,
    parameter int    BN = 2,
    parameter int    BL = $clog2(BN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rxd,
    output logic          str_tvalid,
    output logic [DW-1:0] str_tdata,
    input  logic          str_tready,
    output logic          err_prt,
    output logic          err_frm,
    output logic          err_ovr
);

    localparam bit          PAR_EN  = (PT != "NONE");
    localparam bit          PAR_ODD = (PT == "ODD");
    localparam int          CW      = $clog2(DW + SW + 1);
    localparam logic [BL-1:0] HALF  = BL'((BN - 1) / 2);
    localparam logic [BL-1:0] FULL  = BL'(BN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e        state_q, state_d;
    logic [BL-1:0] cnt_q, cnt_d;
    logic [CW-1:0] bit_q, bit_d;
    logic [DW-1:0] sh_q, sh_d;
    logic          prt_q, prt_d;
    logic          frm_q, frm_d;
    logic          done_q, done_d;
    logic          tvalid_q, tvalid_d;
    logic [DW-1:0] tdata_q, tdata_d;
    logic          eprt_q, eprt_d;
    logic          efrm_q, efrm_d;
    logic          eovr_q, eovr_d;
    logic          rxd_q, prev_q;
    logic          line;
    logic          tick;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], uart_rxd};
    end

    assign line = sync_q[1];
`else
    assign line = uart_rxd;
`endif

    assign tick = (cnt_q == '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        sh_d     = sh_q;
        prt_d    = prt_q;
        frm_d    = frm_q;
        done_d   = 1'b0;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        eprt_d   = 1'b0;
        efrm_d   = 1'b0;
        eovr_d   = 1'b0;

        if (state_q != S_IDLE) cnt_d = tick ? FULL : cnt_q - 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (prev_q && !rxd_q) begin
                    state_d = S_START;
                    cnt_d   = HALF;
                    prt_d   = 1'b0;
                    frm_d   = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rxd_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    sh_d = {rxd_q, sh_q[DW-1:1]};
                    if (bit_q == CW'(DW - 1)) begin
                        bit_d   = '0;
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    prt_d   = rxd_q ^ (^sh_q) ^ PAR_ODD;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (!rxd_q) frm_d = 1'b1;
                    // Leaving mid stop bit lets the next start edge resync early
                    if (bit_q == CW'(SW - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (tvalid_q && str_tready) tvalid_d = 1'b0;

        if (done_q) begin
            if (frm_q) begin
                efrm_d = 1'b1;
            end else begin
                tvalid_d = 1'b1;
                tdata_d  = sh_q;
                eprt_d   = prt_q;
                eovr_d   = tvalid_q && !str_tready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            prt_q    <= 1'b0;
            frm_q    <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            eprt_q   <= 1'b0;
            efrm_q   <= 1'b0;
            eovr_q   <= 1'b0;
            rxd_q    <= 1'b1;
            prev_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            prt_q    <= prt_d;
            frm_q    <= frm_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            eprt_q   <= eprt_d;
            efrm_q   <= efrm_d;
            eovr_q   <= eovr_d;
            rxd_q    <= line;
            prev_q   <= rxd_q;
        end
    end

    assign str_tvalid = tvalid_q;
    assign str_tdata  = tdata_q;
    assign err_prt    = PAR_EN ? eprt_q : 1'b0;
    assign err_frm    = efrm_q;
    assign err_ovr    = eovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx (DW=8, EVEN parity, SW=1, BN=16).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int BN  = 16;
    // start sample at edge+BN/2+2, 10 more bits, then one cycle to output
    localparam int LAT = 10 + 10 * BN + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       tready = 1'b0;
    logic       str_tvalid;
    logic [7:0] str_tdata;
    logic       err_prt, err_frm, err_ovr;

    always #5 clk = ~clk;

    uart_rx #(.DW(8), .PT("EVEN"), .SW(1), .BN(BN)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rxd   (rxd),
        .str_tvalid (str_tvalid),
        .str_tdata  (str_tdata),
        .str_tready (tready),
        .err_prt    (err_prt),
        .err_frm    (err_frm),
        .err_ovr    (err_ovr)
    );

    typedef struct {
        logic [7:0] d;
        bit         prt;
        bit         frm;
        bit         ovr;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0, cyc = 0;
    int   xfers = 0, exp_words = 0, exp_ovrs = 0;
    bit   pend = 0, pv = 0, ptr = 0, nw;
    exp_t me;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic set_ready(bit v);
        tready = v;
        if (v) pend = 0;
    endtask

    task automatic bit_out(logic v);
        rxd = v;
        repeat (BN) @(posedge clk);
        #1;
    endtask

    task automatic send(logic [7:0] d, bit bp, bit bs);
        exp_t e;
        e.d   = d;
        e.prt = bp;
        e.frm = bs;
        e.ovr = !bs && pend && !tready;
        e.cyc = cyc + LAT;
        q.push_back(e);
        if (!bs) begin
            exp_words++;
            if (e.ovr) exp_ovrs++;
            pend = !tready;
        end
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(d[i]);
        bit_out((^d) ^ bp);
        bit_out(!bs);
        if (bs) bit_out(1'b1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            pv  = 0;
            ptr = 0;
        end else begin
            nw = str_tvalid && (!pv || ptr || err_ovr);
            if (nw || err_frm) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected output tvalid=%b frm=%b data=%0h",
                             str_tvalid, err_frm, str_tdata);
                end else begin
                    me = q.pop_front();
                    chk("kind", int'({nw, err_frm}), int'({!me.frm, me.frm}));
                    chk("latency", cyc, me.cyc);
                    if (!me.frm) begin
                        chk("data", int'(str_tdata), int'(me.d));
                        chk("err_prt", int'(err_prt), int'(me.prt));
                        chk("err_ovr", int'(err_ovr), int'(me.ovr));
                    end else begin
                        chk("err_prt_on_frm", int'(err_prt), 0);
                    end
                end
            end else if (err_prt || err_ovr) begin
                checks++;
                errors++;
                $display("FAIL stray pulse prt=%b ovr=%b want 0", err_prt, err_ovr);
            end
            ptr = str_tvalid && tready;
            if (ptr) xfers++;
            pv = str_tvalid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", int'(str_tvalid), 0);
        chk("rst_tdata", int'(str_tdata), 0);
        chk("rst_err_prt", int'(err_prt), 0);
        chk("rst_err_frm", int'(err_frm), 0);
        chk("rst_err_ovr", int'(err_ovr), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        set_ready(1);
        send(8'hA5, 0, 0);
        send(8'h03, 1, 0);
        send(8'h03, 0, 0);
        send(8'h55, 0, 1);

        rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        set_ready(0);
        send(8'h11, 0, 0);
        send(8'h22, 0, 0);
        repeat (5) @(posedge clk);
        #1 set_ready(1);
        repeat (5) @(posedge clk);
        #1;

        e.d   = 8'h00;
        e.prt = 0;
        e.frm = 1;
        e.ovr = 0;
        e.cyc = cyc + LAT;
        q.push_back(e);
        rxd = 1'b0;
        repeat (12 * BN) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (2 * BN) @(posedge clk);
        #1;

        rxd = 1'b0;
        repeat (3 * BN) @(posedge clk);
        #1;
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_tvalid", int'(str_tvalid), 0);
        chk("midrst_tdata", int'(str_tdata), 0);
        repeat (20) @(posedge clk);
        #1;
        send(8'h3C, 0, 0);

        for (int n = 0; n < 24; n++) begin
            set_ready($urandom_range(0, 3) != 0);
            send(8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2) * 7) @(posedge clk);
            #1;
        end

        set_ready(1);
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("transfers", xfers, exp_words - exp_ovrs);
        chk("final_tvalid", int'(str_tvalid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
